wrap_count_monitor: RTL and testbench
=====================================

WRAP_COUNT_MONITOR -- requirements
Module: wrap_count_monitor

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port selector, input, 1 bit: increment strobe seen by the wrap counter under observation.
REQ-004 SHALL have port c, input, 11 bits: count value produced by that counter.
REQ-005 SHALL have port mon_en, input, 1 bit: monitoring enable.
REQ-006 SHALL have port clr_err, input, 1 bit: request to leave FAULT.
REQ-007 SHALL have port exp_c, output, 11 bits: expected value of c this cycle.
REQ-008 SHALL have port state, output, 2 bits: FSM state.
REQ-009 SHALL have port range_err, output, 1 bit: one-cycle pulse for c>500.
REQ-010 SHALL have port step_err, output, 1 bit: one-cycle pulse for c!=exp_c.
REQ-011 SHALL have port fault, output, 1 bit: high exactly while in FAULT.
REQ-012 SHALL have port err_cnt, output, 8 bits: saturating count of error events.
REQ-013 SHALL have port wrap_cnt, output, 16 bits: saturating count of legal 500->1 wraps.

Function
REQ-014 SHALL register c_q<=c and sel_q<=selector on every clock edge in every state.
REQ-015 SHALL drive exp_c combinationally as 0 in IDLE; otherwise 1 if sel_q and c_q==500, c_q+1 (11-bit) if sel_q and c_q!=500, and c_q if !sel_q.
REQ-016 SHALL use states IDLE=0, TRACK=1, FAULT=2; encoding 3 unused and recovering to IDLE.
REQ-017 In IDLE with mon_en=1, the FSM SHALL go to FAULT with range_err pulse if c>500, else go to TRACK with no error.
REQ-018 In TRACK, range_err SHALL assert if c>500 and step_err SHALL assert if c!=exp_c; both may assert together.
REQ-019 In TRACK, any error SHALL move the FSM to FAULT and increment err_cnt by exactly 1 per edge.
REQ-020 Error pulses SHALL be registered: visible for exactly the one cycle following the offending edge, together with fault=1.
REQ-021 In FAULT, no checking SHALL occur and err_cnt SHALL hold.
REQ-022 In FAULT, clr_err=1 with c<=500 SHALL move the FSM to TRACK; clr_err=1 with c>500 SHALL leave it in FAULT.
REQ-023 mon_en=0 SHALL force IDLE on the next edge from any state, with priority over clr_err and error detection.
REQ-024 err_cnt SHALL saturate at 255 and is cleared only by reset.
REQ-025 range_err and step_err SHALL be 0 in every cycle not covered by REQ-020.

Reset
REQ-026 While rst=0, the block SHALL immediately force state=IDLE and exp_c=0, range_err=0, step_err=0, fault=0, err_cnt=0, wrap_cnt=0, c_q=0, sel_q=0.
REQ-027 Reset asserted mid-TRACK or mid-FAULT SHALL discard all history; the first edge after release behaves as IDLE.

Configuration
REQ-028 With macro WRAP_MON_WRAPCNT_EN defined, wrap_cnt SHALL increment (saturating at 65535) on each TRACK edge with c_q==500, sel_q=1, c==1 and no error.
REQ-029 Without WRAP_MON_WRAPCNT_EN, port wrap_cnt SHALL remain present, tied to 0, with no counter logic.

Structure
REQ-030 Package wrap_mon_pkg SHALL hold the state enum, CW=11, WRAP_MAX=500, WRAP_RESTART=1, ERR_W=8 and WRAP_W=16.
REQ-031 Expected-value logic SHALL be one combinational sub-module, wrap_exp_calc (inputs c_q, sel_q; output exp).

Verification
REQ-032 Scenario: rst pulse; mon_en=1; c drives 0,1..500,1 with selector=1 -> no error pulses, state=TRACK throughout, wrap_cnt=1 (macro on) or 0 (macro off).
REQ-033 Scenario: in TRACK, sel=1 and c goes 5->7 -> next cycle step_err=1, fault=1, err_cnt=1; the following cycle step_err=0.
REQ-034 Scenario: in TRACK, c goes 500->501 with sel=1 -> range_err=1 and step_err=1 in the same cycle, err_cnt +1 only.
REQ-035 Scenario: in FAULT with clr_err=1 and c=20 -> TRACK next cycle; with clr_err=1 and c=600 -> stays FAULT, err_cnt unchanged.
REQ-036 Scenario: in TRACK, selector=0 and c goes 10->11 -> step_err pulse; 300 forced errors -> err_cnt=255.
REQ-037 Scenario: rst=0 mid-TRACK with err_cnt=3 -> same cycle state=IDLE, err_cnt=0, all outputs 0.

Source files
------------

// File: rtl/wrap_mon_pkg.sv
// ---------------------------------------------------------------------------
// wrap_mon_pkg
// Shared types and constants for the wrap counter monitor.
//   state_t      : monitor FSM states (IDLE/TRACK/FAULT; encoding 3 unused)
//   CW           : width of the observed count value
//   WRAP_MAX     : largest legal count; the counter wraps after it
//   WRAP_RESTART : value the counter restarts at after WRAP_MAX
//   ERR_W        : width of the saturating error-event counter
//   WRAP_W       : width of the saturating legal-wrap counter
//   out_of_range : helper, true when a count exceeds WRAP_MAX
// ---------------------------------------------------------------------------
package wrap_mon_pkg;

    localparam int CW           = 11;
    localparam int WRAP_MAX     = 500;
    localparam int WRAP_RESTART = 1;
    localparam int ERR_W        = 8;
    localparam int WRAP_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    function automatic logic out_of_range(input logic [CW-1:0] v);
        return v > CW'(WRAP_MAX);
    endfunction

endpackage

// File: rtl/wrap_count_monitor_if.sv
// ---------------------------------------------------------------------------
// wrap_count_monitor_if
// Bundles the observed-counter inputs and the monitor result outputs.
//   selector  : increment strobe seen by the counter under observation
//   c         : count value produced by that counter
//   mon_en    : monitoring enable
//   clr_err   : request to leave FAULT
//   exp_c     : expected value of c this cycle
//   state     : monitor FSM state
//   range_err : one-cycle pulse, c exceeded WRAP_MAX
//   step_err  : one-cycle pulse, c differed from exp_c
//   fault     : high while in FAULT
//   err_cnt   : saturating count of error events
//   wrap_cnt  : saturating count of legal WRAP_MAX -> WRAP_RESTART wraps
// Modports: slave = the monitor, master = whoever drives the observed counter.
// ---------------------------------------------------------------------------
interface wrap_count_monitor_if;
    import wrap_mon_pkg::*;

    logic              selector;
    logic [CW-1:0]     c;
    logic              mon_en;
    logic              clr_err;
    logic [CW-1:0]     exp_c;
    logic [1:0]        state;
    logic              range_err;
    logic              step_err;
    logic              fault;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;

    modport slave (
        input  selector, c, mon_en, clr_err,
        output exp_c, state, range_err, step_err, fault, err_cnt, wrap_cnt
    );

    modport master (
        output selector, c, mon_en, clr_err,
        input  exp_c, state, range_err, step_err, fault, err_cnt, wrap_cnt
    );
endinterface

// File: rtl/wrap_count_monitor_exp_calc.sv
// ---------------------------------------------------------------------------
// wrap_exp_calc
// Purely combinational prediction of the next count from last cycle's
// registered count and strobe.
//   c_q   : count value captured on the previous edge
//   sel_q : increment strobe captured on the previous edge
//   exp   : value the counter should show now
// ---------------------------------------------------------------------------
module wrap_exp_calc
    import wrap_mon_pkg::*;
(
    input  logic [CW-1:0] c_q,
    input  logic          sel_q,
    output logic [CW-1:0] exp
);

    always_comb begin
        exp = c_q;
        if (sel_q) begin
            if (c_q == CW'(WRAP_MAX)) begin
                exp = CW'(WRAP_RESTART);
            end else begin
                // plain 11-bit increment; overflow wraps naturally
                exp = c_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wrap_count_monitor.sv
// ---------------------------------------------------------------------------
// wrap_count_monitor
// Watches an external 1..500 wrap counter and flags illegal values (range)
// and illegal transitions (step). Errors push the FSM into FAULT, which is
// left only through clr_err with a legal count, or by dropping mon_en.
//   clk : single clock, rising edge
//   rst : asynchronous, active-low reset
//   mon : wrap_count_monitor_if.slave, all monitor inputs/outputs
// Optional feature: define WRAP_MON_WRAPCNT_EN to count legal 500->1 wraps;
// otherwise wrap_cnt is tied to zero.
// ---------------------------------------------------------------------------
module wrap_count_monitor
    import wrap_mon_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wrap_count_monitor_if.slave  mon
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_c_q;
    logic             r_sel_q;
    logic             r_range_err;
    logic             r_step_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic [CW-1:0]    w_exp_raw;
    logic             w_c_over;
    logic             w_step_mis;
    logic             w_range_next;
    logic             w_step_next;
    logic             w_err_inc;

    wrap_exp_calc u_exp_calc (
        .c_q   (r_c_q),
        .sel_q (r_sel_q),
        .exp   (w_exp_raw)
    );

    assign w_c_over   = out_of_range(mon.c);
    assign w_step_mis = (mon.c != w_exp_raw);

    // Next state and the error pulses to register on this edge.
    always_comb begin
        w_state_next = r_state;
        w_range_next = 1'b0;
        w_step_next  = 1'b0;
        w_err_inc    = 1'b0;
        if (!mon.mon_en) begin
            // disabling wins over clear requests and error detection
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_c_over) begin
                        w_state_next = FAULT;
                        w_range_next = 1'b1;
                        w_err_inc    = 1'b1;
                    end else begin
                        w_state_next = TRACK;
                    end
                end
                TRACK: begin
                    w_range_next = w_c_over;
                    w_step_next  = w_step_mis;
                    if (w_c_over || w_step_mis) begin
                        w_state_next = FAULT;
                        w_err_inc    = 1'b1;
                    end
                end
                FAULT: begin
                    if (mon.clr_err && !w_c_over) begin
                        w_state_next = TRACK;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_c_q       <= '0;
            r_sel_q     <= 1'b0;
            r_range_err <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_c_q       <= mon.c;
            r_sel_q     <= mon.selector;
            r_range_err <= w_range_next;
            r_step_err  <= w_step_next;
            if (w_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

`ifdef WRAP_MON_WRAPCNT_EN
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              w_wrap_inc;

    // A wrap is legal only on an error-free TRACK edge from 500 to 1.
    assign w_wrap_inc = mon.mon_en && (r_state == TRACK)
                        && !w_c_over && !w_step_mis
                        && r_sel_q && (r_c_q == CW'(WRAP_MAX))
                        && (mon.c == CW'(WRAP_RESTART));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap_cnt <= '0;
        end else if (w_wrap_inc && (r_wrap_cnt != '1)) begin
            r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
        end
    end

    assign mon.wrap_cnt = r_wrap_cnt;
`else
    assign mon.wrap_cnt = '0;
`endif

    assign mon.exp_c     = (r_state == IDLE) ? '0 : w_exp_raw;
    assign mon.state     = r_state;
    assign mon.range_err = r_range_err;
    assign mon.step_err  = r_step_err;
    assign mon.fault     = (r_state == FAULT);
    assign mon.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_wrap_count_monitor.sv
// ---------------------------------------------------------------------------
// tb_wrap_count_monitor
// Directed bench for wrap_count_monitor. Each step drives one cycle of
// stimulus on the falling edge, queues the outcome expected after the next
// rising edge, and compares it one time unit after that edge.
// ---------------------------------------------------------------------------
module tb_wrap_count_monitor;
    import wrap_mon_pkg::*;

`ifdef WRAP_MON_WRAPCNT_EN
    localparam logic [15:0] WRAP_EXP = 16'd1;
`else
    localparam logic [15:0] WRAP_EXP = 16'd0;
`endif

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        rng;
        logic        stp;
        logic        flt;
        logic [7:0]  ecnt;
        logic [15:0] wcnt;
        logic [10:0] expc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;
    logic [15:0] exp_wrap;
    exp_t sb_q[$];

    wrap_count_monitor_if mon_if();

    wrap_count_monitor u_dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    // One clock of stimulus plus its expected result after the edge.
    task automatic step(input logic sel, input logic [10:0] cv, input logic men,
                        input logic clr, input logic [1:0] est, input logic erng,
                        input logic estp, input logic [7:0] eec, input string tag);
        exp_t e;
        exp_t got;
        mon_if.selector = sel;
        mon_if.c        = cv;
        mon_if.mon_en   = men;
        mon_if.clr_err  = clr;
        e.tag  = tag;
        e.st   = est;
        e.rng  = erng;
        e.stp  = estp;
        e.flt  = (est == FAULT);
        e.ecnt = eec;
        e.wcnt = exp_wrap;
        if (est == IDLE)      e.expc = 11'd0;
        else if (!sel)        e.expc = cv;
        else if (cv == 11'd500) e.expc = 11'd1;
        else                  e.expc = cv + 11'd1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk(got.tag, "state",     32'(mon_if.state),     32'(got.st));
        chk(got.tag, "range_err", 32'(mon_if.range_err), 32'(got.rng));
        chk(got.tag, "step_err",  32'(mon_if.step_err),  32'(got.stp));
        chk(got.tag, "fault",     32'(mon_if.fault),     32'(got.flt));
        chk(got.tag, "err_cnt",   32'(mon_if.err_cnt),   32'(got.ecnt));
        chk(got.tag, "wrap_cnt",  32'(mon_if.wrap_cnt),  32'(got.wcnt));
        chk(got.tag, "exp_c",     32'(mon_if.exp_c),     32'(got.expc));
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, "state",     32'(mon_if.state),     32'(IDLE));
        chk(tag, "range_err", 32'(mon_if.range_err), 32'd0);
        chk(tag, "step_err",  32'(mon_if.step_err),  32'd0);
        chk(tag, "fault",     32'(mon_if.fault),     32'd0);
        chk(tag, "err_cnt",   32'(mon_if.err_cnt),   32'd0);
        chk(tag, "wrap_cnt",  32'(mon_if.wrap_cnt),  32'd0);
        chk(tag, "exp_c",     32'(mon_if.exp_c),     32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        exp_wrap = 16'd0;
        rst      = 1'b0;
        mon_if.selector = 1'b0;
        mon_if.c        = 11'd0;
        mon_if.mon_en   = 1'b0;
        mon_if.clr_err  = 1'b0;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // full legal run 0,1..500,1
        step(1'b1, 11'd0, 1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd0, "run_start");
        for (int v = 1; v <= 500; v++) begin
            step(1'b1, 11'(v), 1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd0, "run");
        end
        exp_wrap = WRAP_EXP;
        step(1'b1, 11'd1, 1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd0, "wrap");

        // skip 5 -> 7
        for (int v = 2; v <= 5; v++) begin
            step(1'b1, 11'(v), 1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd0, "pre_skip");
        end
        step(1'b1, 11'd7, 1'b1, 1'b0, FAULT, 1'b0, 1'b1, 8'd1, "skip");
        step(1'b1, 11'd7, 1'b1, 1'b0, FAULT, 1'b0, 1'b0, 8'd1, "skip_after");

        // clear attempts
        step(1'b1, 11'd600, 1'b1, 1'b1, FAULT, 1'b0, 1'b0, 8'd1, "clr_bad");
        step(1'b1, 11'd20,  1'b1, 1'b1, TRACK, 1'b0, 1'b0, 8'd1, "clr_ok");
        step(1'b1, 11'd21,  1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd1, "post_clr");

        // disable, re-arm near the top, then overrun 500 -> 501
        step(1'b1, 11'd21,  1'b0, 1'b0, IDLE,  1'b0, 1'b0, 8'd1, "disable");
        step(1'b1, 11'd499, 1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd1, "rearm");
        step(1'b1, 11'd500, 1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd1, "at_max");
        step(1'b1, 11'd501, 1'b1, 1'b0, FAULT, 1'b1, 1'b1, 8'd2, "overrun");
        step(1'b1, 11'd501, 1'b1, 1'b0, FAULT, 1'b0, 1'b0, 8'd2, "overrun_after");

        // change without a strobe
        step(1'b0, 11'd10, 1'b1, 1'b1, TRACK, 1'b0, 1'b0, 8'd2, "clr_nosel");
        step(1'b0, 11'd11, 1'b1, 1'b0, FAULT, 1'b0, 1'b1, 8'd3, "nosel_change");
        step(1'b0, 11'd11, 1'b1, 1'b1, TRACK, 1'b0, 1'b0, 8'd3, "clr_again");
        step(1'b0, 11'd11, 1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd3, "hold");

        // asynchronous reset mid-TRACK
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_wrap = 16'd0;
        @(negedge clk);
        rst = 1'b1;

        // first edge after reset acts as IDLE; disable beats a bad value
        step(1'b1, 11'd3,   1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd0, "post_rst");
        step(1'b1, 11'd100, 1'b0, 1'b1, IDLE,  1'b0, 1'b0, 8'd0, "dis_prio");
        step(1'b0, 11'd0,   1'b1, 1'b0, TRACK, 1'b0, 1'b0, 8'd0, "sat_arm");

        // 300 forced errors, each cleared again
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ec;
            ec = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            step(1'b0, 11'd5, 1'b1, 1'b0, FAULT, 1'b0, 1'b1, ec, "sat_err");
            step(1'b0, 11'd0, 1'b1, 1'b1, TRACK, 1'b0, 1'b0, ec, "sat_clr");
        end

        // out-of-range value seen while arming from IDLE
        step(1'b0, 11'd0,   1'b0, 1'b0, IDLE,  1'b0, 1'b0, 8'd255, "sat_dis");
        step(1'b1, 11'd700, 1'b1, 1'b0, FAULT, 1'b1, 1'b0, 8'd255, "idle_range");
        step(1'b1, 11'd700, 1'b1, 1'b1, FAULT, 1'b0, 1'b0, 8'd255, "idle_range_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
